// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Sequencer and arbiter for the single shared main-memory port. It accepts
// block-fill requests from the I-cache and D-cache miss handlers plus
// single-word write-through stores from the D-cache. Transactions are
// serialised onto the memory. Issued and returned words are counted, and
// returned data is steered back to the cache that asked for it.
//
// Arbitration happens only in IDLE, with fixed priority store > D fill > I fill.
// A granted transaction is never preempted.
//
// Ports
//   clk, rst               system clock; synchronous active-high reset
//   i_req / i_addr         I-cache block-fill request, miss byte address
//   d_req / d_addr         D-cache block-fill request, miss byte address
//   d_wr_req / d_wr_addr / d_wr_data
//                          D-cache write-through store
//   mem_en / mem_wr / mem_addr / mem_wdata
//                          memory command port (one access per cycle)
//   mem_rdata / mem_valid  in-order read return from memory
//   fill_data / fill_word  returned word and its offset within the block
//   i_fill_we / d_fill_we  line write strobes for the owning cache
//   i_done / d_done        one-cycle pulse on the last word of a fill
//   d_wr_ack               one-cycle pulse when the store is issued
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int BLOCK_WORDS = 8,
    parameter int WORD_BITS   = 3
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_req,
    input  logic [15:0]          i_addr,
    input  logic                 d_req,
    input  logic [15:0]          d_addr,
    input  logic                 d_wr_req,
    input  logic [15:0]          d_wr_addr,
    input  logic [15:0]          d_wr_data,

    output logic                 mem_en,
    output logic                 mem_wr,
    output logic [15:0]          mem_addr,
    output logic [15:0]          mem_wdata,
    input  logic [15:0]          mem_rdata,
    input  logic                 mem_valid,

    output logic [15:0]          fill_data,
    output logic [WORD_BITS-1:0] fill_word,
    output logic                 i_fill_we,
    output logic                 d_fill_we,
    output logic                 i_done,
    output logic                 d_done,
    output logic                 d_wr_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FILL_I = 2'd2,
        FILL_D = 2'd3
    } state_e;

    // The issue counter needs one extra bit so it can rest at BLOCK_WORDS
    // once every read of the block has been sent.
    localparam int                    CNT_BITS    = WORD_BITS + 1;
    localparam logic [15:0]           OFFSET_MASK = 16'(2 * BLOCK_WORDS - 1);
    localparam logic [CNT_BITS-1:0]   ISSUE_FULL  = CNT_BITS'(BLOCK_WORDS);
    localparam logic [WORD_BITS-1:0]  LAST_WORD   = WORD_BITS'(BLOCK_WORDS - 1);

    state_e                state_q,     state_d;
    logic [CNT_BITS-1:0]   issue_cnt_q, issue_cnt_d;
    logic [WORD_BITS-1:0]  recv_cnt_q,  recv_cnt_d;
    logic [15:0]           base_q,      base_d;

    logic                  fill_is_d;
    logic                  last_word;

    assign fill_is_d = (state_q == FILL_D);
    assign last_word = (recv_cnt_q == LAST_WORD);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        base_d      = base_q;

        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = '0;
        fill_word   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        d_wr_ack    = 1'b0;

        // Outputs are held at 0 while reset is asserted. This means a fill
        // aborted by reset can never emit a late strobe or done pulse in the
        // reset cycle itself.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (d_wr_req) begin
                        state_d = WRITE;
                    end else if (d_req) begin
                        state_d = FILL_D;
                        base_d  = d_addr & ~OFFSET_MASK;
                    end else if (i_req) begin
                        state_d = FILL_I;
                        base_d  = i_addr & ~OFFSET_MASK;
                    end
                end

                WRITE: begin
                    mem_en    = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = d_wr_addr;
                    mem_wdata = d_wr_data;
                    d_wr_ack  = 1'b1;
                    state_d   = IDLE;
                end

                FILL_I, FILL_D: begin
                    // Issue side: one read per cycle until the block is covered.
                    mem_addr = base_q + 16'({issue_cnt_q, 1'b0});
                    if (issue_cnt_q < ISSUE_FULL) begin
                        mem_en      = 1'b1;
                        issue_cnt_d = issue_cnt_q + 1'b1;
                    end

                    // Receive side. This runs independently of issue, so both
                    // can happen in the same cycle.
                    if (mem_valid) begin
                        fill_data  = mem_rdata;
                        fill_word  = recv_cnt_q;
                        i_fill_we  = !fill_is_d;
                        d_fill_we  = fill_is_d;
                        recv_cnt_d = recv_cnt_q + 1'b1;
                        if (last_word) begin
                            i_done      = !fill_is_d;
                            d_done      = fill_is_d;
                            issue_cnt_d = '0;
                            recv_cnt_d  = '0;
                            state_d     = IDLE;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, whatever order the simulator evaluates blocks in.
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            base_q      <= base_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed and randomised bench for mem_arbiter. A behavioural memory with a
// configurable in-order latency serves the reads. A monitor logs every memory
// access, fill strobe, done pulse and store ack with its cycle number. Each
// step then checks those logs against the block/timing rules. Cycle n is the
// interval after rising edge n. A request driven in cycle c is granted at
// edge c+1, so the first read goes out in cycle c+1.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr_req;
    logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_done, d_done, d_wr_ack;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_arbiter #(.BLOCK_WORDS(BW), .WORD_BITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wr_req  (d_wr_req),
        .d_wr_addr (d_wr_addr),
        .d_wr_data (d_wr_data),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .fill_data (fill_data),
        .fill_word (fill_word),
        .i_fill_we (i_fill_we),
        .d_fill_we (d_fill_we),
        .i_done    (i_done),
        .d_done    (d_done),
        .d_wr_ack  (d_wr_ack)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- memory
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a * 16'd40503) ^ 16'h5A5A;
    endfunction

    typedef struct { logic [15:0] addr; int due; } rd_t;
    rd_t pend[$];
    int  lat_tab[$];
    int  mem_lat  = 4;
    int  last_due = 0;
    bit  stray    = 1'b0;

    // Capture issued reads mid-cycle; reset discards anything in flight.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            pend.delete();
            last_due = 0;
        end else if (mem_en && !mem_wr) begin
            int l;
            int due;
            l   = (lat_tab.size() > 0) ? lat_tab.pop_front() : mem_lat;
            due = cyc + l;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{mem_addr, due});
        end
    end

    // Return data in issue order; also injects a stray valid on request.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            mem_valid = 1'b1;
            mem_rdata = mem_fn(pend[0].addr);
            void'(pend.pop_front());
        end else if (stray) begin
            mem_valid = 1'b1;
            mem_rdata = 16'($urandom);
            stray     = 1'b0;
        end else begin
            mem_valid = 1'b0;
            mem_rdata = 16'($urandom);
        end
    end

    // --------------------------------------------------------------- monitor
    typedef struct { int cyc; logic [15:0] addr; logic wr; logic [15:0] wdata; } acc_t;
    typedef struct { int cyc; bit is_d; logic [2:0] word; logic [15:0] data; } fill_t;
    typedef struct { int cyc; bit is_d; } done_t;
    acc_t  accs[$];
    fill_t fills[$];
    done_t dones[$];
    int    acks[$];

    initial forever begin
        @(negedge clk);
        if (mem_en)    accs.push_back('{cyc, mem_addr, mem_wr, mem_wdata});
        if (i_fill_we) fills.push_back('{cyc, 1'b0, fill_word, fill_data});
        if (d_fill_we) fills.push_back('{cyc, 1'b1, fill_word, fill_data});
        if (i_done)    dones.push_back('{cyc, 1'b0});
        if (d_done)    dones.push_back('{cyc, 1'b1});
        if (d_wr_ack)  acks.push_back(cyc);
    end

    // Requesters drop their request on the edge after done/ack.
    initial forever begin
        @(negedge clk);
        if (i_done) begin @(posedge clk); #1; i_req = 1'b0; end
    end
    initial forever begin
        @(negedge clk);
        if (d_done) begin @(posedge clk); #1; d_req = 1'b0; end
    end
    initial forever begin
        @(negedge clk);
        if (d_wr_ack) begin @(posedge clk); #1; d_wr_req = 1'b0; end
    end

    // ---------------------------------------------------------------- checks
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fixed_ret(input int g, input int l, output int r[8]);
        for (int k = 0; k < BW; k++) r[k] = g + k + l;
    endtask

    task automatic check_fill(input bit is_d, input logic [15:0] addr, input int g,
                              input int ret[8]);
        logic [15:0] base;
        acc_t  a;
        fill_t f;
        done_t dn;
        base = addr - (addr % 16'(2 * BW));
        for (int k = 0; k < BW; k++) begin
            check("rd_present", 32'(accs.size() > 0), 1);
            if (accs.size() > 0) begin
                a = accs.pop_front();
                check("rd_cycle", a.cyc, g + k);
                check("rd_addr",  a.addr, base + 16'(2 * k));
                check("rd_is_read", a.wr, 0);
                check("rd_wdata_zero", a.wdata, 0);
            end
        end
        for (int k = 0; k < BW; k++) begin
            check("fill_present", 32'(fills.size() > 0), 1);
            if (fills.size() > 0) begin
                f = fills.pop_front();
                check("fill_cycle", f.cyc, ret[k]);
                check("fill_owner", f.is_d, is_d);
                check("fill_word",  f.word, k);
                check("fill_data",  f.data, mem_fn(base + 16'(2 * k)));
            end
        end
        check("done_present", 32'(dones.size() > 0), 1);
        if (dones.size() > 0) begin
            dn = dones.pop_front();
            check("done_cycle", dn.cyc, ret[BW-1]);
            check("done_owner", dn.is_d, is_d);
        end
    endtask

    task automatic check_write(input logic [15:0] addr, input logic [15:0] data, input int g);
        acc_t a;
        int   k;
        check("wr_present", 32'(accs.size() > 0), 1);
        if (accs.size() > 0) begin
            a = accs.pop_front();
            check("wr_cycle", a.cyc, g);
            check("wr_flag",  a.wr, 1);
            check("wr_addr",  a.addr, addr);
            check("wr_data",  a.wdata, data);
        end
        check("ack_present", 32'(acks.size() > 0), 1);
        if (acks.size() > 0) begin
            k = acks.pop_front();
            check("ack_cycle", k, g);
        end
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_extra_access"}, accs.size(), 0);
        check({tag, "_extra_fill"},   fills.size(), 0);
        check({tag, "_extra_done"},   dones.size(), 0);
        check({tag, "_extra_ack"},    acks.size(), 0);
        accs.delete(); fills.delete(); dones.delete(); acks.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                    i_fill_we, d_fill_we, i_done, d_done, d_wr_ack}, '0);
    endtask

    // Wait (bounded) until all requests have been served and memory is quiet.
    task automatic wait_quiet();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!i_req && !d_req && !d_wr_req && pend.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("quiet_within_bound", 32'(ok), 1);
        repeat (2) @(negedge clk);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int          c, g, g2, kind, lat;
        int          r[8], r2[8];
        logic [15:0] a, a2, wd;

        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0;
        i_addr = '0; d_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        mem_valid = 1'b0; mem_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_outputs");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("idle_outputs");
        check_empty("reset");

        // I miss alone
        mem_lat = 4;
        @(posedge clk); #1; i_addr = 16'h1236; i_req = 1'b1; c = cyc;
        wait_quiet();
        fixed_ret(c + 1, 4, r);
        check_fill(1'b0, 16'h1236, c + 1, r);
        check_empty("i_alone");

        // Simultaneous D and I fill: D first, I two edges after d_done
        @(posedge clk); #1;
        d_addr = 16'h0040; i_addr = 16'h0100; d_req = 1'b1; i_req = 1'b1; c = cyc;
        wait_quiet();
        fixed_ret(c + 1, 4, r);
        check_fill(1'b1, 16'h0040, c + 1, r);
        fixed_ret(r[BW-1] + 2, 4, r2);
        check_fill(1'b0, 16'h0100, r[BW-1] + 2, r2);
        check_empty("d_then_i");

        // Store has priority over a D fill
        @(posedge clk); #1;
        d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF; d_addr = 16'h3010;
        d_wr_req = 1'b1; d_req = 1'b1; c = cyc;
        wait_quiet();
        check_write(16'h2002, 16'hBEEF, c + 1);
        fixed_ret(c + 3, 4, r);
        check_fill(1'b1, 16'h3010, c + 3, r);
        check_empty("store_prio");

        // Store raised during an I fill waits until after i_done
        @(posedge clk); #1; i_addr = 16'h0456; i_req = 1'b1; c = cyc;
        g = c + 1;
        while (cyc < g + 3) begin @(posedge clk); #1; end
        d_wr_addr = 16'h0A0C; d_wr_data = 16'h1234; d_wr_req = 1'b1;
        wait_quiet();
        fixed_ret(g, 4, r);
        check_fill(1'b0, 16'h0456, g, r);
        check_write(16'h0A0C, 16'h1234, r[BW-1] + 2);
        check_empty("store_in_fill");

        // Irregular latency: returns in cycles 4,5,9,10,11,14,15,16
        lat_tab = '{4, 4, 7, 7, 7, 9, 9, 9};
        @(posedge clk); #1; d_addr = 16'h7789; d_req = 1'b1; c = cyc;
        g = c + 1;
        wait_quiet();
        r = '{g + 4, g + 5, g + 9, g + 10, g + 11, g + 14, g + 15, g + 16};
        check_fill(1'b1, 16'h7789, g, r);
        check_empty("gaps");

        // Reset in cycle 6 of a D fill
        mem_lat = 4;
        @(posedge clk); #1; d_addr = 16'h5554; d_req = 1'b1; c = cyc;
        g = c + 1;
        while (cyc < g + 6) begin @(posedge clk); #1; end
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_midfill_outputs");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_reset_outputs");
        check("reset_reads_issued", accs.size(), 6);
        check("reset_words_filled", fills.size(), 2);
        accs.delete(); fills.delete();
        @(posedge clk); #1 stray = 1'b1;
        repeat (4) @(negedge clk);
        check_empty("reset_abort");

        @(posedge clk); #1; d_addr = 16'h5554; d_req = 1'b1; c = cyc;
        wait_quiet();
        fixed_ret(c + 1, 4, r);
        check_fill(1'b1, 16'h5554, c + 1, r);
        check_empty("after_reset_fill");

        // Randomised single transactions
        for (int n = 0; n < 20; n++) begin
            kind = int'($urandom_range(2, 0));
            a    = 16'($urandom);
            wd   = 16'($urandom);
            lat  = int'($urandom_range(6, 1));
            mem_lat = lat;
            @(posedge clk); #1;
            c = cyc;
            case (kind)
                0: begin d_wr_addr = a; d_wr_data = wd; d_wr_req = 1'b1; end
                1: begin d_addr = a; d_req = 1'b1; end
                default: begin i_addr = a; i_req = 1'b1; end
            endcase
            wait_quiet();
            if (kind == 0) begin
                check_write(a, wd, c + 1);
            end else begin
                fixed_ret(c + 1, lat, r);
                check_fill(kind == 1, a, c + 1, r);
            end
            check_empty("random");
        end

        // Randomised D + I pair with random latency
        a   = 16'($urandom);
        a2  = 16'($urandom);
        lat = int'($urandom_range(6, 1));
        mem_lat = lat;
        @(posedge clk); #1; d_addr = a; i_addr = a2; d_req = 1'b1; i_req = 1'b1; c = cyc;
        wait_quiet();
        fixed_ret(c + 1, lat, r);
        check_fill(1'b1, a, c + 1, r);
        g2 = r[BW-1] + 2;
        fixed_ret(g2, lat, r2);
        check_fill(1'b0, a2, g2, r2);
        check_empty("random_pair");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
